// File: rtl/temp_alarm_trigger_if.sv
// Sample stream in, alarm/peak status out, between the sensor reader side
// and the temperature alarm trigger.
interface temp_alarm_trigger_if #(
  parameter int DATA_W = 13
);
  logic [DATA_W-1:0] temp_data;
  logic              temp_valid;
  logic              enable;
  logic              clear_peak;
  logic              alarm_pulse;
  logic              over_temp;
  logic [DATA_W-1:0] peak_temp;

  modport master (
    output temp_data, temp_valid, enable, clear_peak,
    input  alarm_pulse, over_temp, peak_temp
  );

  modport slave (
    input  temp_data, temp_valid, enable, clear_peak,
    output alarm_pulse, over_temp, peak_temp
  );
endinterface

// File: rtl/temp_alarm_trigger.sv
// Over-temperature alarm: signed threshold with N-sample confirmation,
// release hysteresis, pulse holdoff and a running peak tracker.
module temp_alarm_trigger #(
  parameter int          DATA_W    = 13,
  parameter int          HIGH_TH   = 480,
  parameter int          HYST      = 32,
  parameter int unsigned CONFIRM   = 3,
  parameter int unsigned SYS_FREQ  = 100000000,
  parameter int unsigned HOLDOFF_S = 20
) (
  input  logic                  clk,
  input  logic                  reset,
  temp_alarm_trigger_if.slave   bus
);

  localparam int HW = (CONFIRM > 1) ? $clog2(CONFIRM + 1) : 1;
  localparam logic [HW-1:0]     CONFIRM_C = HW'(CONFIRM);
  localparam logic [31:0]       HOLDOFF   = 32'(64'(SYS_FREQ) * 64'(HOLDOFF_S));
  localparam logic signed [31:0] HIGH_C   = 32'(HIGH_TH);
  localparam logic signed [31:0] REL_C    = 32'(HIGH_TH - HYST);
  localparam logic [DATA_W-1:0] PEAK_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_NORMAL,
    S_CONFIRM,
    S_ALARMED
  } state_t;

  state_t            state_q, state_d;
  logic [HW-1:0]     hit_cnt_q, hit_cnt_d;
  logic [31:0]       holdoff_q;
  logic              alarm_pulse_q, over_temp_q;
  logic [DATA_W-1:0] peak_q;
  logic              fire, pulse_d, over_d;

  logic signed [31:0] sample_ext;
  logic               hit, rel;

  assign sample_ext = {{(32-DATA_W){bus.temp_data[DATA_W-1]}}, bus.temp_data};
  assign hit        = (sample_ext >= HIGH_C);
  assign rel        = (sample_ext <= REL_C);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_NORMAL;
      hit_cnt_q     <= '0;
      holdoff_q     <= '0;
      alarm_pulse_q <= 1'b0;
      over_temp_q   <= 1'b0;
      peak_q        <= PEAK_MIN;
    end else begin
      state_q       <= state_d;
      hit_cnt_q     <= hit_cnt_d;
      alarm_pulse_q <= pulse_d;
      over_temp_q   <= over_d;
      if (pulse_d)
        holdoff_q <= HOLDOFF;
      else if (holdoff_q != '0)
        holdoff_q <= holdoff_q - 32'd1;
      // a sample arriving with clear_peak wins over the reset-to-minimum
      if (bus.temp_valid &&
          (bus.clear_peak || ($signed(bus.temp_data) > $signed(peak_q))))
        peak_q <= bus.temp_data;
      else if (bus.clear_peak)
        peak_q <= PEAK_MIN;
    end
  end

  always_comb begin
    state_d   = state_q;
    hit_cnt_d = hit_cnt_q;
    fire      = 1'b0;
    if (!bus.enable) begin
      state_d   = S_NORMAL;
      hit_cnt_d = '0;
    end else if (bus.temp_valid) begin
      case (state_q)
        S_NORMAL: begin
          if (hit) begin
            if (CONFIRM_C == HW'(1)) begin
              fire = 1'b1;
            end else begin
              state_d   = S_CONFIRM;
              hit_cnt_d = HW'(1);
            end
          end
        end
        S_CONFIRM: begin
          if (hit) begin
            if (hit_cnt_q + HW'(1) == CONFIRM_C)
              fire = 1'b1;
            else
              hit_cnt_d = hit_cnt_q + HW'(1);
          end else begin
            state_d   = S_NORMAL;
            hit_cnt_d = '0;
          end
        end
        S_ALARMED: begin
          if (rel)
            state_d = S_NORMAL;
        end
        default: begin
          state_d   = S_NORMAL;
          hit_cnt_d = '0;
        end
      endcase
    end
    if (fire) begin
      state_d   = S_ALARMED;
      hit_cnt_d = '0;
    end
  end

  // a confirmed alarm during holdoff still raises over_temp, just silently
  always_comb begin
    pulse_d = fire && (holdoff_q == '0);
    over_d  = (state_d == S_ALARMED);
  end

  assign bus.alarm_pulse = alarm_pulse_q;
  assign bus.over_temp   = over_temp_q;
  assign bus.peak_temp   = peak_q;

endmodule

// File: doc/temp_alarm_trigger.md
# temp_alarm_trigger

Watches the stream of temperature samples from the sensor reader and decides when the LED flasher fires. It applies signed threshold comparison, N-sample confirmation, hysteresis and a re-trigger holdoff. It emits a single-cycle `alarm_pulse` that drives the flasher's `control` input, plus a level `over_temp` flag and a running peak temperature for the display path.

## Interface
- `DATA_W`, 13: sample width, signed two's complement at 0.0625 °C/LSB.
- `HIGH_TH`, 480: signed alarm threshold in LSBs (30 °C).
- `HYST`, 32: release hysteresis in LSBs (2 °C). Must be ≥ 0.
- `CONFIRM`, 3: consecutive qualifying samples needed to alarm. Must be ≥ 1.
- `SYS_FREQ`, 100000000: clock frequency in Hz.
- `HOLDOFF_S`, 20: minimum seconds between pulses. `SYS_FREQ*HOLDOFF_S` must be < 2^32.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `temp_data`  in  DATA_W  signed temperature sample.
- `temp_valid`  in  1  one-cycle strobe; `temp_data` is valid this cycle.
- `enable`  in  1  alarm evaluation enable.
- `clear_peak`  in  1  one-cycle request to reset the peak tracker.
- `alarm_pulse`  out  1  one-cycle pulse that feeds the flasher `control`.
- `over_temp`  out  1  level flag; high while in ALARMED.
- `peak_temp`  out  DATA_W  largest sample seen since reset or clear.

## Operation
- All comparisons are signed.
  - `temp_data` is sign-extended to 32 bits.
  - Hit: sample ≥ `HIGH_TH`.
  - Release: sample ≤ `HIGH_TH - HYST`.
- `HOLDOFF = SYS_FREQ*HOLDOFF_S`, held in a 32-bit `holdoff_cnt`.
  - On every cycle where `alarm_pulse` is registered high, the counter loads `HOLDOFF`.
  - Otherwise it decrements toward 0 and saturates at 0.
  - It keeps running regardless of `enable` or state.
- FSM states: NORMAL, CONFIRM, ALARMED. `hit_cnt` has width $clog2(CONFIRM+1).
- NORMAL (`over_temp`=0):
  - Valid hit: `hit_cnt`=1. If `CONFIRM`=1, do the fire step below; otherwise go to CONFIRM.
  - Valid non-hit: no change.
- CONFIRM:
  - Valid hit: `hit_cnt`++. On reaching `CONFIRM`, do the fire step.
  - Valid non-hit: return to NORMAL with `hit_cnt`=0.
  - Cycles without `temp_valid`: hold state and count.
- Fire step:
  - Go to ALARMED and clear `hit_cnt`.
  - Assert `alarm_pulse` only if `holdoff_cnt`==0.
  - If the holdoff is still active, enter ALARMED silently (`over_temp`=1, no pulse).
- ALARMED (`over_temp`=1):
  - Valid release sample: go to NORMAL.
  - Samples between the release level and `HIGH_TH`, and further hits: stay in ALARMED, no pulse.
- `enable`=0 forces NORMAL with `hit_cnt`=0 on the next edge and ignores samples for the FSM. Holdoff and peak keep working.
- Peak tracker:
  - On `temp_valid` with `temp_data` > `peak_temp`, load `temp_data`. This happens regardless of `enable`.
  - `clear_peak` loads the most negative value, -2^(DATA_W-1).
  - `clear_peak` and `temp_valid` in the same cycle: load `temp_data`.
- Reset values:
  - State NORMAL, `hit_cnt`=0, `holdoff_cnt`=0.
  - `alarm_pulse`=0, `over_temp`=0.
  - `peak_temp`=-2^(DATA_W-1) (0x1000 at the default width).

## Timing
- Every output is a register. Nothing is combinational from the inputs.
- Latency from `temp_valid` to outputs:
  - The confirming `temp_valid` is sampled at edge t. `alarm_pulse` and `over_temp` are high after edge t.
  - `alarm_pulse` is high for exactly one cycle.
  - `peak_temp` updates after the same edge it is sampled at.
- The flasher ignores `control` while it runs, so `HOLDOFF_S` is set ≥ the flasher period.
- The earliest next pulse is HOLDOFF+1 cycles after the previous one.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. A pulse in flight is dropped.
- Back-to-back `temp_valid` (every cycle) must be supported with no lost samples.

## Test plan
Bench parameters: defaults except `SYS_FREQ`=10, `HOLDOFF_S`=2, giving HOLDOFF = 20 cycles.

- Reset: assert `reset` asynchronously between edges → outputs 0 immediately, `peak_temp`=0x1000.
- Confirmation: samples 500, 500, 500, then a one-cycle idle gap → single 1-cycle `alarm_pulse` after the third sample's edge. `over_temp`=1. `peak_temp`=500.
- Broken run: 500, 500, 470, 500, 500 → no pulse. A further 500 → pulse.
- Hysteresis: from ALARMED, sample 460 → `over_temp` stays 1. Sample 448 → `over_temp`=0 on the next cycle.
- Holdoff:
  - Re-alarm within 20 cycles of the first pulse → `over_temp`=1 with no pulse.
  - Release, then confirm again after the counter reaches 0 → pulse.
- Peak, enable and reset:
  - Samples -100, then 200 with `enable`=0 → no alarm, `peak_temp`=200.
  - `clear_peak` together with a valid 50 → `peak_temp`=50.
  - `reset` asserted while in CONFIRM with `hit_cnt`=2 → next 500 sample needs three hits again.
